// File: rtl/lz77_pkg.sv
// Shared constants, widths and types for the LZ77 encoder/decoder pair.
package lz77_pkg;

  localparam int unsigned SB_DEPTH = 9;
  localparam int unsigned LA_DEPTH = 8;
  localparam logic [7:0]  END_CHAR = 8'h24;

  localparam int unsigned POS_W    = 4;
  localparam int unsigned LEN_W    = 3;
  localparam int unsigned MAX_LEN  = LA_DEPTH - 1;
  localparam int unsigned SB_CNT_W = $clog2(SB_DEPTH + 1);
  localparam int unsigned LA_CNT_W = $clog2(LA_DEPTH + 1);
  localparam int unsigned LA_IDX_W = $clog2(LA_DEPTH);

  typedef enum logic [2:0] {FILL, MATCH, EMIT, SHIFT, DONE} state_e;

  typedef logic [SB_DEPTH-1:0][7:0] sb_t;
  typedef logic [LA_DEPTH-1:0][7:0] la_t;

endpackage

// File: rtl/lz77_match_unit.sv
// Combinational longest-match search over the search window, overlap into the
// look-ahead allowed; ties resolve to the nearest position.
module lz77_match_unit
  import lz77_pkg::*;
(
  input  logic [SB_DEPTH-1:0][7:0] i_sb,
  input  logic [LA_DEPTH-1:0][7:0] i_la,
  input  logic [SB_CNT_W-1:0]      i_sb_cnt,
  input  logic [LA_CNT_W-1:0]      i_la_cnt,
  output logic [POS_W-1:0]         o_best_pos,
  output logic [LEN_W-1:0]         o_best_len
);

  localparam int unsigned XW   = SB_DEPTH + LA_DEPTH - 1;
  localparam int unsigned XI_W = $clog2(XW);

  logic [XW-1:0][7:0] w_x;
  int                 w_cap;
  int                 w_run;
  int                 w_best_len;
  int                 w_best_pos;
  logic               w_run_on;

  // w_x[SB_DEPTH+j] is X[j]: oldest window entry at index 0, LA[0] at SB_DEPTH.
  always_comb begin
    for (int i = 0; i < int'(SB_DEPTH); i++) w_x[i] = i_sb[SB_DEPTH-1-i];
    for (int j = 0; j < int'(MAX_LEN); j++) w_x[SB_DEPTH+j] = i_la[j];

    w_cap = (i_la_cnt == '0) ? 0 : int'(i_la_cnt) - 1;
    if (w_cap > int'(MAX_LEN)) w_cap = int'(MAX_LEN);

    w_best_len = 0;
    w_best_pos = 0;
    w_run      = 0;
    w_run_on   = 1'b0;
    for (int p = 0; p < int'(SB_DEPTH); p++) begin
      w_run    = 0;
      w_run_on = (p < int'(i_sb_cnt));
      for (int k = 0; k < int'(MAX_LEN); k++) begin
        if (w_run_on && (k < w_cap) &&
            (w_x[XI_W'(int'(SB_DEPTH) + k)] == w_x[XI_W'(int'(SB_DEPTH) + k - p - 1)]))
          w_run = w_run + 1;
        else
          w_run_on = 1'b0;
      end
      if (w_run > w_best_len) begin
        w_best_len = w_run;
        w_best_pos = p;
      end
    end

    o_best_pos = POS_W'(w_best_pos);
    o_best_len = LEN_W'(w_best_len);
  end

endmodule

// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder producing (code_pos, code_len, chardata) triples from
// a '$'-terminated character stream.
module lz77_encoder
  import lz77_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] code_pos,
  output logic [LEN_W-1:0] code_len,
  output logic [7:0]       chardata,
  output logic             finish
);

  state_e              r_state;
  sb_t                 r_sb;
  la_t                 r_la;
  logic [SB_CNT_W-1:0] r_sb_cnt;
  logic [LA_CNT_W-1:0] r_la_cnt;
  logic [LEN_W:0]      r_shift_cnt;
  logic                r_end_seen;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_finish;
  logic [POS_W-1:0]    r_pos;
  logic [LEN_W-1:0]    r_len;
  logic [7:0]          r_char;

  logic [POS_W-1:0]    w_best_pos;
  logic [LEN_W-1:0]    w_best_len;
  logic                w_in_xfer;
  logic                w_fill_done;
  logic [LA_CNT_W-1:0] w_la_cnt_inc;

  lz77_match_unit u_match (
    .i_sb       (r_sb),
    .i_la       (r_la),
    .i_sb_cnt   (r_sb_cnt),
    .i_la_cnt   (r_la_cnt),
    .o_best_pos (w_best_pos),
    .o_best_len (w_best_len)
  );

  assign w_in_xfer    = in_valid & r_in_ready;
  assign w_la_cnt_inc = r_la_cnt + 1'b1;
  assign w_fill_done  = r_end_seen | (r_la_cnt == LA_CNT_W'(LA_DEPTH)) |
                        (w_in_xfer & ((in_char == END_CHAR) |
                                      (w_la_cnt_inc == LA_CNT_W'(LA_DEPTH))));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FILL;
      r_sb        <= '0;
      r_la        <= '0;
      r_sb_cnt    <= '0;
      r_la_cnt    <= '0;
      r_shift_cnt <= '0;
      r_end_seen  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_finish    <= 1'b0;
      r_pos       <= '0;
      r_len       <= '0;
      r_char      <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_xfer) begin
            r_la[r_la_cnt[LA_IDX_W-1:0]] <= in_char;
            r_la_cnt                     <= w_la_cnt_inc;
            if (in_char == END_CHAR) r_end_seen <= 1'b1;
          end
          if (w_fill_done) begin
            r_in_ready <= 1'b0;
            r_state    <= MATCH;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        MATCH: begin
          r_pos       <= w_best_pos;
          r_len       <= w_best_len;
          r_char      <= r_la[w_best_len];
          r_out_valid <= 1'b1;
          r_state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_shift_cnt <= {1'b0, r_len} + 1'b1;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Copied characters plus the literal move from look-ahead into the window.
          r_sb        <= {r_sb[SB_DEPTH-2:0], r_la[0]};
          r_la        <= {8'h00, r_la[LA_DEPTH-1:1]};
          r_la_cnt    <= r_la_cnt - 1'b1;
          r_shift_cnt <= r_shift_cnt - 1'b1;
          if (r_sb_cnt < SB_CNT_W'(SB_DEPTH)) r_sb_cnt <= r_sb_cnt + 1'b1;
          if (r_shift_cnt == (LEN_W+1)'(1)) begin
            if (r_la[0] == END_CHAR) begin
              r_finish <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state  <= FILL;
            end
          end
        end
        DONE: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_finish    <= 1'b1;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign code_pos  = r_pos;
  assign code_len  = r_len;
  assign chardata  = r_char;
  assign finish    = r_finish;

endmodule
